// File: rtl/fplan_pkg.sv
// Shared types and sizing for the floorplanner net-to-edge stream stage.
package fplan_pkg;

   localparam int NODE_W   = 8;
   localparam int WIDTH_W  = 12;
   localparam int MAX_PINS = 4;
   localparam int CNT_W    = $clog2(MAX_PINS + 1);
   localparam int IDX_W    = $clog2(MAX_PINS);

   typedef logic [NODE_W-1:0]  node_id_t;
   typedef logic [WIDTH_W-1:0] net_width_t;
   typedef logic [CNT_W-1:0]   pin_cnt_t;
   typedef logic [IDX_W-1:0]   pin_idx_t;

   typedef struct packed {
      node_id_t   a;
      node_id_t   b;
      net_width_t weight;
      logic       last;
   } edge_t;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } fsm_t;

   // Unsigned maximum of two net widths.
   function automatic net_width_t width_max(input net_width_t x, input net_width_t y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/fplan_pin_buf.sv
// Per-net pin buffer: stores distinct node ids in arrival order, flags
// whether a node is already present, and exposes two read ports for the
// pair iterator in the top.
module fplan_pin_buf
   import fplan_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     clear,
   input  logic     wr_en,
   input  node_id_t wr_node,
   input  pin_idx_t rd_idx_a,
   input  pin_idx_t rd_idx_b,
   output node_id_t rd_node_a,
   output node_id_t rd_node_b,
   output logic     hit,
   output logic     full,
   output pin_cnt_t cnt
);

   node_id_t entry_q [MAX_PINS];
   node_id_t entry_d [MAX_PINS];
   pin_cnt_t cnt_q;
   pin_cnt_t cnt_d;

   assign cnt       = cnt_q;
   assign full      = (cnt_q == pin_cnt_t'(MAX_PINS));
   assign rd_node_a = entry_q[rd_idx_a];
   assign rd_node_b = entry_q[rd_idx_b];

   // Parallel compare of the incoming node against every occupied entry.
   always_comb begin
      hit = 1'b0;
      for (int k = 0; k < MAX_PINS; k++) begin
         if ((pin_cnt_t'(k) < cnt_q) && (entry_q[k] == wr_node)) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
   end

   // Next-state for entries and count; clear takes priority over a write.
   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
      if (clear) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (wr_en && !full) begin
         entry_d[cnt_q[IDX_W-1:0]] = wr_node;
         cnt_d                     = cnt_q + pin_cnt_t'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Register file and count state.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < MAX_PINS; k++) begin
            entry_q[k] <= {NODE_W{1'b0}};
         end
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/fplan_net_edge_gen.sv
// Net-to-clique edge generator: collects the distinct pins of one net, then
// streams every pin pair as an edge weighted by the widest width seen.
module fplan_net_edge_gen
   import fplan_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NODE_W-1:0]  in_node,
   input  logic [WIDTH_W-1:0] in_width,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NODE_W-1:0]  out_node_a,
   output logic [NODE_W-1:0]  out_node_b,
   output logic [WIDTH_W-1:0] out_weight,
   output logic               out_last,
   output logic               overflow,
   output logic [15:0]        net_count
);

   fsm_t       state_q, state_d;
   pin_idx_t   i_q, i_d, j_q, j_d;
   net_width_t weight_q, weight_d;
   logic       overflow_q, overflow_d;
   logic [15:0] net_count_q, net_count_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;

   logic       buf_clear_s;
   logic       hit_s, full_s;
   pin_cnt_t   cnt_s, eff_cnt_s;
   node_id_t   rd_a_s, rd_b_s;
   logic       accept_s, store_s, handshake_s;
   logic       j_at_end_s, pair_last_s;

   assign accept_s    = in_valid && in_ready_q;
   assign store_s     = accept_s && !hit_s && !full_s;
   assign eff_cnt_s   = cnt_s + pin_cnt_t'(store_s);
   assign handshake_s = out_valid_q && out_ready;
   assign j_at_end_s  = (pin_cnt_t'(j_q) == (cnt_s - pin_cnt_t'(1)));
   assign pair_last_s = j_at_end_s && (pin_cnt_t'(i_q) == (cnt_s - pin_cnt_t'(2)));

   fplan_pin_buf u_pin_buf (
      .clock     (clock),
      .reset     (reset),
      .clear     (buf_clear_s),
      .wr_en     (store_s),
      .wr_node   (in_node),
      .rd_idx_a  (i_q),
      .rd_idx_b  (j_q),
      .rd_node_a (rd_a_s),
      .rd_node_b (rd_b_s),
      .hit       (hit_s),
      .full      (full_s),
      .cnt       (cnt_s)
   );

   // Output data is forced to zero whenever no edge is being presented.
   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_node_a = out_valid_q ? rd_a_s   : {NODE_W{1'b0}};
   assign out_node_b = out_valid_q ? rd_b_s   : {NODE_W{1'b0}};
   assign out_weight = out_valid_q ? weight_q : {WIDTH_W{1'b0}};
   assign out_last   = out_valid_q && pair_last_s;
   assign overflow   = overflow_q;
   assign net_count  = net_count_q;

   // Next-state: pin collection, pair iteration and net bookkeeping.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      weight_d    = weight_q;
      overflow_d  = overflow_q;
      net_count_d = net_count_q;
      buf_clear_s = 1'b0;
      case (state_q)
         COLLECT: begin
            if (accept_s) begin
               // An empty buffer means this is the first pin of a new net.
               if (cnt_s == {CNT_W{1'b0}}) begin
                  weight_d = in_width;
               end else begin
                  weight_d = width_max(weight_q, in_width);
               end
               if (!hit_s && full_s) begin
                  overflow_d = 1'b1;
               end else begin
                  overflow_d = overflow_q;
               end
               if (in_last) begin
                  if (eff_cnt_s < pin_cnt_t'(2)) begin
                     net_count_d = net_count_q + 16'd1;
                     buf_clear_s = 1'b1;
                  end else begin
                     state_d = EMIT;
                     i_d     = {IDX_W{1'b0}};
                     j_d     = pin_idx_t'(1);
                  end
               end else begin
                  state_d = COLLECT;
               end
            end else begin
               state_d = COLLECT;
            end
         end
         EMIT: begin
            if (handshake_s) begin
               if (pair_last_s) begin
                  net_count_d = net_count_q + 16'd1;
                  buf_clear_s = 1'b1;
                  state_d     = COLLECT;
               end else if (j_at_end_s) begin
                  i_d = i_q + pin_idx_t'(1);
                  j_d = i_q + pin_idx_t'(2);
               end else begin
                  j_d = j_q + pin_idx_t'(1);
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d     = COLLECT;
            buf_clear_s = 1'b1;
         end
      endcase
      in_ready_d  = (state_d == COLLECT);
      out_valid_d = (state_d == EMIT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= COLLECT;
         i_q         <= {IDX_W{1'b0}};
         j_q         <= {IDX_W{1'b0}};
         weight_q    <= {WIDTH_W{1'b0}};
         overflow_q  <= 1'b0;
         net_count_q <= 16'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         weight_q    <= weight_d;
         overflow_q  <= overflow_d;
         net_count_q <= net_count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_fplan_net_edge_gen.sv
// Scoreboard bench for fplan_net_edge_gen: directed nets push expected edges,
// a negedge monitor pops and compares on each output handshake and checks
// that a stalled edge holds steady.
module tb_fplan_net_edge_gen;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [11:0] w;
      logic        last;
   } exp_edge_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_node = 8'd0;
   logic [11:0] in_width = 12'd0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_node_a;
   logic [7:0]  out_node_b;
   logic [11:0] out_weight;
   logic        out_last;
   logic        overflow;
   logic [15:0] net_count;

   int checks = 0;
   int passes = 0;
   logic rand_rdy = 1'b0;
   logic rdy_fixed = 1'b1;
   exp_edge_t exp_q[$];

   fplan_net_edge_gen dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_node    (in_node),
      .in_width   (in_width),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_node_a (out_node_a),
      .out_node_b (out_node_b),
      .out_weight (out_weight),
      .out_last   (out_last),
      .overflow   (overflow),
      .net_count  (net_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0d required %0d", name, got, exp);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [11:0] w, input logic last);
      exp_edge_t e;
      e.a = a; e.b = b; e.w = w; e.last = last;
      exp_q.push_back(e);
   endtask

   // Drives one pin record and waits (bounded) for its transfer.
   task automatic send_pin(input logic [7:0] node, input logic [11:0] width, input logic last);
      logic rdy;
      logic done;
      done = 1'b0;
      in_valid = 1'b1; in_node = node; in_width = width; in_last = last;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clock);
         rdy = in_ready;
         @(posedge clock);
         #1;
         done = rdy;
      end
      if (!done) chk("send_pin_timeout", 32'd0, 32'd1);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Waits (bounded) until all expected edges are consumed and the stage is idle.
   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge clock);
         #2;
         done = (exp_q.size() == 0) && !out_valid;
      end
      if (!done) chk({name, "_drain_timeout"}, exp_q.size(), 32'd0);
   endtask

   // Downstream ready: fixed level or random toggling.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_rdy) out_ready = ($urandom_range(1, 0) != 0);
         else out_ready = rdy_fixed;
      end
   end

   // Monitor: compare on handshake, check hold stability while stalled.
   logic        hold_vld = 1'b0;
   logic [7:0]  hold_a, hold_b;
   logic [11:0] hold_w;
   logic        hold_l;
   always @(negedge clock) begin
      if (reset) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_edge", {out_node_a, out_node_b, out_weight, 3'd0, out_last},
                {hold_a, hold_b, hold_w, 3'd0, hold_l});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_edge", {out_node_a, out_node_b}, 32'd0);
            end else begin
               exp_edge_t e;
               e = exp_q.pop_front();
               chk("edge", {out_node_a, out_node_b, out_weight, 3'd0, out_last},
                   {e.a, e.b, e.w, 3'd0, e.last});
            end
            hold_vld = 1'b0;
         end else if (out_valid) begin
            hold_vld = 1'b1;
            hold_a = out_node_a; hold_b = out_node_b; hold_w = out_weight; hold_l = out_last;
         end else begin
            hold_vld = 1'b0;
         end
      end
   end

   initial begin
      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", {out_node_a, out_node_b, out_weight, out_last}, 32'd0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_net_count", net_count, 16'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);

      // 1: two-pin net, edge on the following cycle.
      push(8'd2, 8'd7, 12'd25, 1'b1);
      send_pin(8'd2, 12'd25, 1'b0);
      send_pin(8'd7, 12'd25, 1'b1);
      chk("t1_latency_valid", out_valid, 1'b1);
      chk("t1_in_ready_low", in_ready, 1'b0);
      wait_idle("t1");
      chk("t1_net_count", net_count, 16'd1);

      // 2: three-pin 900-bit net.
      push(8'd1, 8'd2, 12'd900, 1'b0);
      push(8'd1, 8'd3, 12'd900, 1'b0);
      push(8'd2, 8'd3, 12'd900, 1'b1);
      send_pin(8'd1, 12'd900, 1'b0);
      send_pin(8'd2, 12'd900, 1'b0);
      send_pin(8'd3, 12'd900, 1'b1);
      wait_idle("t2");
      chk("t2_net_count", net_count, 16'd2);

      // 3: single-pin net yields no edge.
      send_pin(8'd4, 12'd0, 1'b1);
      chk("t3_no_edge", out_valid, 1'b0);
      chk("t3_in_ready", in_ready, 1'b1);
      wait_idle("t3");
      chk("t3_net_count", net_count, 16'd3);

      // 4: duplicate pin still raises the weight.
      push(8'd5, 8'd6, 12'd30, 1'b1);
      send_pin(8'd5, 12'd10, 1'b0);
      send_pin(8'd5, 12'd30, 1'b0);
      send_pin(8'd6, 12'd10, 1'b1);
      wait_idle("t4");
      chk("t4_net_count", net_count, 16'd4);
      chk("t4_no_overflow", overflow, 1'b0);

      // 5: six distinct pins, only first four kept; weight covers dropped pins.
      push(8'd10, 8'd11, 12'd50, 1'b0);
      push(8'd10, 8'd12, 12'd50, 1'b0);
      push(8'd10, 8'd13, 12'd50, 1'b0);
      push(8'd11, 8'd12, 12'd50, 1'b0);
      push(8'd11, 8'd13, 12'd50, 1'b0);
      push(8'd12, 8'd13, 12'd50, 1'b1);
      send_pin(8'd10, 12'd5, 1'b0);
      send_pin(8'd11, 12'd6, 1'b0);
      send_pin(8'd12, 12'd7, 1'b0);
      send_pin(8'd13, 12'd8, 1'b0);
      send_pin(8'd14, 12'd9, 1'b0);
      send_pin(8'd15, 12'd50, 1'b1);
      wait_idle("t5");
      chk("t5_net_count", net_count, 16'd5);
      chk("t5_overflow", overflow, 1'b1);

      // 6: random back-pressure on the three-pin net.
      rand_rdy = 1'b1;
      push(8'd1, 8'd2, 12'd900, 1'b0);
      push(8'd1, 8'd3, 12'd900, 1'b0);
      push(8'd2, 8'd3, 12'd900, 1'b1);
      send_pin(8'd1, 12'd900, 1'b0);
      send_pin(8'd2, 12'd900, 1'b0);
      send_pin(8'd3, 12'd900, 1'b1);
      wait_idle("t6");
      rand_rdy = 1'b0;
      chk("t6_net_count", net_count, 16'd6);
      chk("t6_overflow_sticky", overflow, 1'b1);

      // 6b: reset while stalled in EMIT drops the net.
      rdy_fixed = 1'b0;
      @(posedge clock);
      #1;
      send_pin(8'd20, 12'd5, 1'b0);
      send_pin(8'd21, 12'd5, 1'b1);
      repeat (3) @(posedge clock);
      #1;
      chk("t6b_stalled_valid", out_valid, 1'b1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("t6b_rst_out_valid", out_valid, 1'b0);
      chk("t6b_rst_in_ready", in_ready, 1'b0);
      reset = 1'b0;
      rdy_fixed = 1'b1;
      @(posedge clock);
      #1;
      chk("t6b_in_ready", in_ready, 1'b1);
      chk("t6b_net_count", net_count, 16'd0);
      chk("t6b_overflow_cleared", overflow, 1'b0);
      push(8'd3, 8'd4, 12'd2, 1'b1);
      send_pin(8'd3, 12'd1, 1'b0);
      send_pin(8'd4, 12'd2, 1'b1);
      wait_idle("t6c");
      chk("t6c_net_count", net_count, 16'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
